// File: rtl/ag_pkg.sv
// Shared types and constants for the output-buffer address sequencer.
package ag_pkg;

  // Address stepping mode applied each time the channel rotation wraps.
  typedef enum logic [1:0] {
    AG_LINEAR = 2'd0,
    AG_WRAP   = 2'd1,
    AG_STRIDE = 2'd2,
    AG_RSVD   = 2'd3
  } ag_mode_e;

  typedef enum logic [1:0] {
    AG_IDLE = 2'd0,
    AG_RUN  = 2'd1,
    AG_DONE = 2'd2
  } ag_state_e;

  // Default job length is AG_WDEPTH beats per output channel.
  localparam int unsigned AG_WDEPTH = 27;

endpackage

// File: rtl/ag_mod_incr.sv
// Combinational next-address generator for the output-buffer sequencer.
module ag_mod_incr
  import ag_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [ADDR_W-1:0] depth_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W:0] sum;
  logic [ADDR_W:0] folded;
  logic            at_last;

  // Step the address by mode; the extra sum bit keeps the stride wrap free of overflow.
  always_comb begin
    sum     = {1'b0, addr_i} + {1'b0, stride_i};
    folded  = sum;
    at_last = (addr_i == depth_i - ADDR_W'(1));
    addr_o  = addr_i;
    if (sum >= {1'b0, depth_i}) begin
      folded = sum - {1'b0, depth_i};
    end
    unique case (ag_mode_e'(mode_i))
      AG_LINEAR: addr_o = at_last ? addr_i : addr_i + ADDR_W'(1);
      AG_WRAP:   addr_o = at_last ? '0 : addr_i + ADDR_W'(1);
      AG_STRIDE: addr_o = folded[ADDR_W-1:0];
      default:   addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/ag_out_seq.sv
// Address/channel sequencer for the systolic-array output buffer: issues one
// (address, channel) beat per un-stalled cycle for a configured job length.
module ag_out_seq
  import ag_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DEPTH_MAX = 82,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    stall,
  input  logic [1:0]              cfg_mode,
  input  logic [ADDR_W-1:0]       cfg_depth,
  input  logic [ADDR_W-1:0]       cfg_stride,
  input  logic [CNT_W-1:0]        cfg_len,
  output logic [ADDR_W-1:0]       address,
  output logic [$clog2(N_CH)-1:0] ch_sel,
  output logic                    addr_vld,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned CH_W = $clog2(N_CH);
  localparam logic [CH_W-1:0] ChLast = CH_W'(N_CH - 1);

  ag_state_e         state_q, state_d;
  ag_mode_e          mode_q;
  logic [ADDR_W-1:0] depth_q, stride_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              vld_q, vld_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cfg_ok;
  logic              cfg_ld;

  ag_mod_incr #(
    .ADDR_W (ADDR_W)
  ) u_incr (
    .mode_i   (mode_q),
    .addr_i   (addr_q),
    .stride_i (stride_q),
    .depth_i  (depth_q),
    .addr_o   (addr_nxt)
  );

  // Reject any configuration the sequencer cannot walk safely.
  always_comb begin
    cfg_ok = 1'b1;
    if (cfg_depth == '0 || cfg_depth > ADDR_W'(DEPTH_MAX)) cfg_ok = 1'b0;
    if (cfg_len == '0) cfg_ok = 1'b0;
    if (ag_mode_e'(cfg_mode) == AG_RSVD) cfg_ok = 1'b0;
    if (ag_mode_e'(cfg_mode) == AG_STRIDE &&
        (cfg_stride == '0 || cfg_stride >= cfg_depth)) cfg_ok = 1'b0;
  end

  // Next-state and registered-output logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ch_d    = ch_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cfg_ld  = 1'b0;
    if (clear) begin
      state_d = AG_IDLE;
      cnt_d   = '0;
      addr_d  = '0;
      ch_d    = '0;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        AG_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_d = AG_RUN;
              cfg_ld  = 1'b1;
              cnt_d   = '0;
              addr_d  = '0;
              ch_d    = '0;
              vld_d   = !stall;
              busy_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        AG_RUN: begin
          // A beat is consumed only in a cycle where it was presented valid.
          if (vld_q) begin
            if (cnt_q == len_q - CNT_W'(1)) begin
              state_d = AG_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              vld_d   = 1'b0;
              addr_d  = '0;
              ch_d    = '0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              if (ch_q == ChLast) begin
                ch_d   = '0;
                addr_d = addr_nxt;
              end else begin
                ch_d = ch_q + CH_W'(1);
              end
              vld_d = !stall;
            end
          end else begin
            vld_d = !stall;
          end
        end
        AG_DONE: begin
          state_d = AG_IDLE;
        end
        default: begin
          state_d = AG_IDLE;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, counters, outputs and the job configuration latched on start.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= AG_IDLE;
      mode_q   <= AG_LINEAR;
      depth_q  <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      ch_q     <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (cfg_ld) begin
        mode_q   <= ag_mode_e'(cfg_mode);
        depth_q  <= cfg_depth;
        stride_q <= cfg_stride;
        len_q    <= cfg_len;
      end
    end
  end

  assign address  = addr_q;
  assign ch_sel   = ch_q;
  assign addr_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ag_out_seq.sv
// Self-checking bench for ag_out_seq against a beat-indexed reference model.
module tb_ag_out_seq;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned N_CH      = 4;
  localparam int unsigned DEPTH_MAX = 82;
  localparam int unsigned CNT_W     = 16;

  logic              sys_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              clear = 1'b0;
  logic              stall = 1'b0;
  logic [1:0]        cfg_mode = '0;
  logic [ADDR_W-1:0] cfg_depth = '0;
  logic [ADDR_W-1:0] cfg_stride = '0;
  logic [CNT_W-1:0]  cfg_len = '0;
  logic [ADDR_W-1:0] address;
  logic [1:0]        ch_sel;
  logic              addr_vld, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  ag_out_seq #(
    .ADDR_W    (ADDR_W),
    .N_CH      (N_CH),
    .DEPTH_MAX (DEPTH_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .start      (start),
    .clear      (clear),
    .stall      (stall),
    .cfg_mode   (cfg_mode),
    .cfg_depth  (cfg_depth),
    .cfg_stride (cfg_stride),
    .cfg_len    (cfg_len),
    .address    (address),
    .ch_sel     (ch_sel),
    .addr_vld   (addr_vld),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Address of beat b from the job rules: group g = b / N_CH owns one address.
  function automatic int exp_addr(int mode, int depth, int stride, int b);
    int g;
    g = b / N_CH;
    case (mode)
      0:       return (g < depth - 1) ? g : depth - 1;
      1:       return g % depth;
      default: return (g * stride) % depth;
    endcase
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_vld"}, 32'(addr_vld), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_addr"}, 32'(address), 0);
    chk({tag, "_ch"}, 32'(ch_sel), 0);
  endtask

  task automatic set_cfg(input int mode, input int depth, input int stride, input int len);
    cfg_mode   = 2'(mode);
    cfg_depth  = ADDR_W'(depth);
    cfg_stride = ADDR_W'(stride);
    cfg_len    = CNT_W'(len);
  endtask

  // abort_kind: 0 none, 1 clear, 2 reset_n, applied once abort_at beats are issued.
  task automatic run_job(input string tag, input int mode, input int depth, input int stride,
                         input int len, input int stall_pct, input int stall_at,
                         input int start_pct, input int abort_kind, input int abort_at,
                         input int exp_done);
    int b, cyc, stall_left, limit;
    bit stall_prev, fin, used, aborted;
    b = 0; cyc = 1; stall_left = 0; stall_prev = 1'b0;
    fin = 1'b0; used = 1'b0; aborted = 1'b0;
    limit = len * 4 + 40;
    set_cfg(mode, depth, stride, len);
    start = 1'b1;
    step();
    start = 1'b0;
    while (!fin) begin
      if (cyc > limit) begin
        chk({tag, "_timeout"}, 0, 1);
        reset_n = 1'b0; #1; reset_n = 1'b1;
        fin = 1'b1; aborted = 1'b1;
      end else if (b == len) begin
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_done_busy"}, 32'(busy), 0);
        chk({tag, "_done_vld"}, 32'(addr_vld), 0);
        chk({tag, "_done_addr"}, 32'(address), 0);
        chk({tag, "_done_ch"}, 32'(ch_sel), 0);
        if (exp_done >= 0) chk({tag, "_done_cyc"}, cyc, exp_done);
        fin = 1'b1;
      end else begin
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_nodone"}, 32'(done), 0);
        chk({tag, "_noerr"}, 32'(err), 0);
        chk({tag, "_vld"}, 32'(addr_vld), 32'(!stall_prev));
        if (!stall_prev) begin
          chk({tag, "_addr"}, 32'(address), exp_addr(mode, depth, stride, b));
          chk({tag, "_ch"}, 32'(ch_sel), b % N_CH);
          b++;
        end
      end
      if (!aborted && abort_kind == 1 && b == abort_at && b < len) begin
        // Clear together with stall and start: clear must win.
        clear = 1'b1; stall = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; stall = 1'b0; start = 1'b0;
        chk_quiet({tag, "_clr"});
        step();
        chk_quiet({tag, "_clr2"});
        fin = 1'b1; aborted = 1'b1;
      end else if (!aborted && abort_kind == 2 && b == abort_at && b < len) begin
        reset_n = 1'b0;
        #1;
        chk_quiet({tag, "_rst"});
        step();
        reset_n = 1'b1;
        step();
        chk_quiet({tag, "_rst2"});
        fin = 1'b1; aborted = 1'b1;
      end else if (!aborted) begin
        if (stall_at >= 0 && b == stall_at && !used) begin
          stall_left = 3;
          used = 1'b1;
        end
        stall_prev = (stall_left > 0) || (int'($urandom_range(99)) < stall_pct);
        if (stall_left > 0) stall_left--;
        stall = stall_prev;
        start = (int'($urandom_range(99)) < start_pct);
        cfg_mode   = 2'($urandom);
        cfg_depth  = ADDR_W'($urandom);
        cfg_stride = ADDR_W'($urandom);
        cfg_len    = CNT_W'($urandom);
        step();
        cyc++;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    if (!aborted) chk_quiet({tag, "_idle"});
  endtask

  task automatic illegal(input string tag, input int mode, input int depth, input int stride,
                         input int len);
    set_cfg(mode, depth, stride, len);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_err"}, 32'(err), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_vld"}, 32'(addr_vld), 0);
    step();
    chk({tag, "_err_clr"}, 32'(err), 0);
    chk({tag, "_busy2"}, 32'(busy), 0);
    step();
    chk({tag, "_busy3"}, 32'(busy), 0);
  endtask

  initial begin
    int mode, depth, stride, len;
    #1;
    chk_quiet("rst_hold");
    step();
    step();
    chk_quiet("rst_hold2");
    reset_n = 1'b1;
    step();
    chk_quiet("rst_rel");

    run_job("lin3", 0, 3, 0, 16, 0, -1, 0, 0, 0, 17);
    run_job("wrap3", 1, 3, 0, 20, 0, -1, 0, 0, 0, 21);
    run_job("str5", 2, 5, 2, 20, 0, -1, 0, 0, 0, 21);
    run_job("stall3", 0, 4, 0, 16, 0, 6, 25, 0, 0, 20);
    run_job("maxd", 1, DEPTH_MAX, 0, 9, 0, -1, 0, 0, 0, 10);
    run_job("len1", 2, 7, 6, 1, 0, -1, 50, 0, 0, 2);

    illegal("ill_d0", 0, 0, 0, 8);
    illegal("ill_str", 2, 5, 5, 8);
    illegal("ill_m3", 3, 5, 1, 8);
    illegal("ill_len0", 1, 5, 1, 0);
    illegal("ill_dmax", 0, DEPTH_MAX + 1, 0, 8);

    run_job("clr7", 0, 3, 0, 16, 0, -1, 0, 1, 7, -1);
    run_job("after_clr", 0, 3, 0, 16, 0, -1, 0, 0, 0, 17);
    run_job("rst7", 0, 3, 0, 16, 0, -1, 0, 2, 7, -1);
    run_job("after_rst", 1, 3, 0, 20, 0, -1, 0, 0, 0, 21);

    for (int j = 0; j < 40; j++) begin
      mode  = int'($urandom_range(2));
      depth = int'($urandom_range(DEPTH_MAX, 1));
      if (mode == 2 && depth == 1) mode = 1;
      stride = (mode == 2) ? int'($urandom_range(depth - 1, 1)) : int'($urandom_range(255));
      len = int'($urandom_range(60, 1));
      run_job("rnd", mode, depth, stride, len, 20, -1, 10, 0, 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
